// File: rtl/trace_pkg.sv
// Shared widths, entry layout and helpers for the register-write tracer.
package trace_pkg;
  localparam int REG_W       = 5;
  localparam int DATA_W      = 32;
  localparam int DROP_W      = 16;
  localparam int STAMP_W_DEF = 16;

  // Entry layout at the default stamp width; the top re-declares it with its own STAMP_W.
  typedef struct packed {
    logic [STAMP_W_DEF-1:0] stamp;
    logic [REG_W-1:0]       regno;
    logic [DATA_W-1:0]      data;
  } trace_entry_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/regwrite_tracer_if.sv
// Regfile write tap plus the valid/ready drain port of the tracer.
interface regwrite_tracer_if #(parameter int STAMP_W = 16);
  import trace_pkg::*;

  logic                ctrl_writeEnable;
  logic [REG_W-1:0]    ctrl_writeReg;
  logic [DATA_W-1:0]   data_writeReg;
  logic                out_valid;
  logic                out_ready;
  logic [REG_W-1:0]    out_reg;
  logic [DATA_W-1:0]   out_data;
  logic [STAMP_W-1:0]  out_stamp;

  modport master (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, out_ready,
    output out_valid, out_reg, out_data, out_stamp
  );

  modport slave (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, out_ready,
    input  out_valid, out_reg, out_data, out_stamp
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; full/empty derive from the occupancy counter.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  // Zero when empty so the head never shows stale or uninitialised storage.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/regwrite_tracer.sv
// Timestamps every non-r0 regfile write into a FIFO drained over valid/ready.
module regwrite_tracer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  regwrite_tracer_if.master        bus,
  input  logic                     trace_en,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);
  typedef struct packed {
    logic [STAMP_W-1:0] stamp;
    logic [REG_W-1:0]   regno;
    logic [DATA_W-1:0]  data;
  } entry_t;

  logic [STAMP_W-1:0] stamp;
  logic               capture, pop_fire, drop, full, empty;
  entry_t             wr_e, rd_e;

  assign capture  = trace_en & bus.ctrl_writeEnable & (bus.ctrl_writeReg != '0);
  assign pop_fire = bus.out_valid & bus.out_ready;
  assign drop     = capture & full & ~pop_fire;

  assign wr_e = '{stamp: stamp, regno: bus.ctrl_writeReg, data: bus.data_writeReg};

  trace_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (capture),
    .pop   (bus.out_ready),
    .flush (flush),
    .wdata (wr_e),
    .rdata (rd_e),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_reg   = rd_e.regno;
  assign bus.out_data  = rd_e.data;
  assign bus.out_stamp = rd_e.stamp;

  // Stamp keeps counting through flush; only reset restarts it.
  always_ff @(posedge clock) begin
    if (reset) stamp <= '0;
    else       stamp <= stamp + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end
  end
endmodule

// File: tb/tb_regwrite_tracer.sv
// Randomised and directed bench for regwrite_tracer against a queue-based model.
module tb_regwrite_tracer;
  logic clock = 0, reset = 1, trace_en = 0, flush = 0;
  logic [4:0]  lvl_a, lvl_b;
  logic        ovf_a, ovf_b;
  logic [15:0] drp_a, drp_b;
  int n_chk = 0, n_err = 0;

  regwrite_tracer_if #(.STAMP_W(16)) if_a ();
  regwrite_tracer_if #(.STAMP_W(4))  if_b ();

  regwrite_tracer #(.DEPTH(16), .STAMP_W(16)) dut_a (
    .clock(clock), .reset(reset), .bus(if_a.master), .trace_en(trace_en), .flush(flush),
    .level(lvl_a), .overflow(ovf_a), .drop_count(drp_a));

  regwrite_tracer #(.DEPTH(16), .STAMP_W(4)) dut_b (
    .clock(clock), .reset(reset), .bus(if_b.master), .trace_en(trace_en), .flush(flush),
    .level(lvl_b), .overflow(ovf_b), .drop_count(drp_b));

  always #5 clock = ~clock;

  typedef struct { logic [15:0] stamp; logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t        q[$];
  logic [15:0] m_cnt = 0;
  logic        m_ovf = 0;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d, input logic rdy);
    if_a.ctrl_writeEnable = we; if_a.ctrl_writeReg = rd; if_a.data_writeReg = d; if_a.out_ready = rdy;
    if_b.ctrl_writeEnable = we; if_b.ctrl_writeReg = rd; if_b.data_writeReg = d; if_b.out_ready = rdy;
  endtask

  // One clock: advance the model from the inputs seen at the edge, then compare.
  task automatic step();
    bit cap, pop, dropped;
    @(posedge clock);
    cap = trace_en && if_a.ctrl_writeEnable && (if_a.ctrl_writeReg != 0);
    pop = (q.size() > 0) && if_a.out_ready;
    dropped = 0;
    if (reset) begin
      q.delete(); m_cnt = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (flush) begin
        q.delete(); m_ovf = 0; m_drop = 0;
      end else begin
        if (cap && q.size() == 16 && !pop) begin
          dropped = 1; m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
        if (pop) void'(q.pop_front());
        if (cap && !dropped) q.push_back('{m_cnt, if_a.ctrl_writeReg, if_a.data_writeReg});
      end
      m_cnt++;
    end
    #1;
    chk("valid_a", if_a.out_valid, q.size() != 0);
    chk("valid_b", if_b.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("reg_a",   if_a.out_reg,   q[0].rd);
      chk("data_a",  if_a.out_data,  q[0].data);
      chk("stamp_a", if_a.out_stamp, q[0].stamp);
      chk("reg_b",   if_b.out_reg,   q[0].rd);
      chk("data_b",  if_b.out_data,  q[0].data);
      chk("stamp_b", if_b.out_stamp, q[0].stamp[3:0]);
    end
    chk("level_a", lvl_a, q.size());
    chk("level_b", lvl_b, q.size());
    chk("ovf_a",   ovf_a, m_ovf);
    chk("ovf_b",   ovf_b, m_ovf);
    chk("drop_a",  drp_a, m_drop);
    chk("drop_b",  drp_b, m_drop);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, if_a.out_valid, 0);
    chk({tag, "_reg"},   if_a.out_reg,   0);
    chk({tag, "_data"},  if_a.out_data,  0);
    chk({tag, "_stamp"}, if_a.out_stamp, 0);
    chk({tag, "_level"}, lvl_a, 0);
    chk({tag, "_ovf"},   ovf_a, 0);
    chk({tag, "_drop"},  drp_a, 0);
  endtask

  task automatic do_reset();
    reset = 1; drive(0, 0, 0, 0); flush = 0;
    step();
    check_reset_vals("rst");
    reset = 0;
  endtask

  initial begin
    trace_en = 1;
    drive(0, 0, 0, 0);
    step();
    do_reset();

    // single write at stamp 5
    repeat (5) step();
    drive(1, 5'd3, 32'hDEADBEEF, 0);
    step();
    drive(0, 0, 0, 0);
    chk("single_valid", if_a.out_valid, 1);
    chk("single_reg",   if_a.out_reg,   3);
    chk("single_data",  if_a.out_data,  32'hDEADBEEF);
    chk("single_stamp", if_a.out_stamp, 5);
    chk("single_level", lvl_a, 1);

    // drain, then r0 and disabled writes must not be captured
    drive(0, 0, 0, 1); step();
    drive(1, 5'd0, 32'h1, 0); step();
    trace_en = 0; drive(1, 5'd7, 32'h2, 0); step();
    trace_en = 1; drive(0, 0, 0, 0);
    chk("filter_level", lvl_a, 0);
    chk("filter_drop",  drp_a, 0);

    // fill and overflow: 18 writes, 2 dropped
    for (int i = 0; i < 18; i++) begin
      drive(1, 5'((i % 31) + 1), 32'h1000 + i, 0);
      step();
    end
    chk("fill_level", lvl_a, 16);
    chk("fill_ovf",   ovf_a, 1);
    chk("fill_drop",  drp_a, 2);

    // push+pop on full keeps level, no extra drop
    drive(1, 5'd9, 32'h9999, 1); step();
    chk("pp_level", lvl_a, 16);
    chk("pp_drop",  drp_a, 2);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step();
    chk("pp_last_reg",  if_a.out_reg,  9);
    chk("pp_last_data", if_a.out_data, 32'h9999);
    step();
    chk("pp_empty", if_a.out_valid, 0);

    // flush with a simultaneous capture, after an overflow
    for (int i = 0; i < 17; i++) begin drive(1, 5'd4, i, 0); step(); end
    flush = 1; drive(1, 5'd6, 32'h66, 0); step();
    flush = 0; drive(0, 0, 0, 0);
    chk("flush_level", lvl_a, 0);
    chk("flush_valid", if_a.out_valid, 0);
    chk("flush_ovf",   ovf_a, 0);
    chk("flush_drop",  drp_a, 0);

    // reset mid-drain, then the stamp restarts at 0
    for (int i = 0; i < 5; i++) begin drive(1, 5'd2, 32'hA0 + i, 0); step(); end
    drive(0, 0, 0, 1); step(); step();
    do_reset();
    drive(1, 5'd11, 32'hB, 0); step();
    chk("post_rst_stamp", if_a.out_stamp, 0);

    // stamp wrap on the 4-bit instance: captures at cycles 15 and 16
    do_reset();
    drive(0, 0, 0, 0);
    repeat (15) step();
    drive(1, 5'd1, 32'hF, 0); step();
    chk("wrap_first", if_b.out_stamp, 15);
    drive(1, 5'd1, 32'h10, 0); step();
    drive(0, 0, 0, 1); step();
    chk("wrap_second_b", if_b.out_stamp, 0);
    chk("wrap_second_a", if_a.out_stamp, 16);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      trace_en = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 70));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regwrite_tracer.md
# regwrite_tracer

Captures every architectural register write from the processor's regfile write port into a timestamped trace FIFO. Entries drain through a valid/ready port, e.g. to a UART dumper or testbench monitor. Sits directly downstream of the processor/regfile pair, tapping `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg`. Test benches use it to compare committed register state cycle-by-cycle against a golden model.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `STAMP_W`, 16: timestamp width in bits.
- `clock` in 1: sole clock; connect to the regfile clock so each sample aligns with one regfile write.
- `reset` in 1: synchronous, active-high.
- `trace_en` in 1: capture enable; when low, writes are ignored (not counted as drops).
- `flush` in 1: synchronous FIFO clear; the timestamp keeps running.
- `ctrl_writeEnable` in 1: regfile write enable tap.
- `ctrl_writeReg` in 5: regfile destination tap.
- `data_writeReg` in 32: regfile write data tap.
- `out_valid` out 1: head entry is available.
- `out_ready` in 1: consumer accepts the head entry.
- `out_reg` out 5: head entry's register number.
- `out_data` out 32: head entry's data.
- `out_stamp` out STAMP_W: head entry's cycle stamp.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set on the first dropped write.
- `drop_count` out 16: dropped writes, saturating at 16'hFFFF.

## Operation
- **Capture condition:** `trace_en & ctrl_writeEnable & (ctrl_writeReg != 5'd0)`. Writes to r0 are architecturally void and are never recorded.
- **Entry format:** {stamp, reg, data}, 53 bits at the default widths.
- **Stamp:** free-running counter. It is 0 in the first cycle after reset, increments every cycle, and wraps modulo 2^STAMP_W without any flag. An entry takes the counter value of its capture cycle.
- **Pop:** occurs when `out_valid & out_ready`. The FIFO is show-ahead: `out_*` always presents the oldest entry. When `out_valid` is 0, the `out_*` fields are don't-care, but they must not be X after reset (drive 0).
- **Full FIFO with a capture:**
  - Pop in the same cycle: accept the push. `level` stays at DEPTH.
  - No pop: drop the write, set `overflow`, increment `drop_count` (saturating).
- **Empty FIFO with a capture:** no same-cycle bypass. The entry appears on `out_*` the next cycle.
- **Pop and push in the same cycle, not full:** both take effect; `level` is unchanged.
- **`flush`:**
  - Empties the FIFO: pointers and `level` go to 0, `out_valid` goes to 0.
  - Clears `overflow` and `drop_count`.
  - A capture in the same cycle is discarded. Flush has priority over push and pop.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `level`.

## Timing
- **Reset values:** `out_valid`=0, `out_reg`=0, `out_data`=0, `out_stamp`=0, `level`=0, `overflow`=0, `drop_count`=0. The stamp counter is 0.
- **Reset mid-operation:** all contents are lost and the state above is re-established on the next edge.
- **Capture latency:** 1 cycle from the capturing edge to `out_valid`=1 (FIFO previously empty).
- **Pop latency:** the next entry, if any, is presented the cycle after a pop. Sustained throughput is 1 entry/cycle with `out_ready` held high.
- **Consumer handshake:** `out_*` stay stable while `out_valid & ~out_ready`.
- **Producer:** no handshake. The processor is never stalled; backpressure manifests only as drops.
- **`level`, `overflow`, `drop_count`:** registered; they reflect the state after the previous edge.

## Structure
- **Package `trace_pkg`:**
  - `REG_W`=5, `DATA_W`=32.
  - Entry struct/typedef `trace_entry_t` {stamp, reg, data}.
  - `DROP_W`=16.
- **Sub-module `trace_fifo`:** generic synchronous show-ahead FIFO with parameters WIDTH and DEPTH, ports push/pop/flush/full/empty/level, register-array storage.
- **Top level holds:** the capture qualifier, the stamp counter, the overflow/drop logic, and entry packing/unpacking.

## Test plan
- **Single write:** after reset, write r3=32'hDEADBEEF at stamp 5 with `out_ready`=0. Next cycle: `out_valid`=1, `out_reg`=3, `out_data`=DEADBEEF, `out_stamp`=5, `level`=1.
- **r0 and disable filtering:** write r0=1, then r7=2 with `trace_en`=0. Expect `level` to stay 0 and `drop_count`=0.
- **Fill and overflow:** DEPTH=16 with `out_ready`=0, 18 back-to-back writes. Expect `level`=16, `overflow`=1, `drop_count`=2. Draining yields the first 16 in order, with stamps consecutive.
- **Push+pop on full:** full FIFO, write r9 with `out_ready`=1. Expect `level`=16, `drop_count` unchanged, and r9 as the last entry drained.
- **Flush/reset priority:** assert `flush` together with a capture. Next cycle: `level`=0, `out_valid`=0, `overflow`=0. Assert `reset` mid-drain and check every reset value.
- **Stamp wrap:** STAMP_W=4, capture at cycles 15 and 16. Expect stamps 15 then 0.
